// File: rtl/act_sparse_encoder_pkg.sv
// act_sparse_encoder_pkg: shared sparse activation format parameters and helpers
package act_sparse_encoder_pkg;
    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_CHANNEL_DEPTH = 32;
    typedef enum logic {FILL = 1'b0, FULL = 1'b1} bank_st_t;
    function automatic int C_LOG_2(input int n);
        int r = 0;
        for (int i = 0; i < 31; i++) if ((1 << i) < n) r = i + 1;
        return r;
    endfunction
endpackage

// File: rtl/act_sparse_encoder_if.sv
// act_sparse_encoder_if: dense input and encoded block handshake bundle
interface act_sparse_encoder_if
    import act_sparse_encoder_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int CHANNEL_DEPTH = DEF_CHANNEL_DEPTH
);
    logic                                in_vld;
    logic                                in_rdy;
    logic [DATA_WIDTH-1:0]               in_dat;
    logic                                out_vld;
    logic                                out_rdy;
    logic [CHANNEL_DEPTH-1:0]            out_flg;
    logic [DATA_WIDTH*CHANNEL_DEPTH-1:0] out_dat;
    logic [C_LOG_2(CHANNEL_DEPTH):0]     out_cnt;
    modport master(output in_vld, in_dat, out_rdy, input in_rdy, out_vld, out_flg, out_dat, out_cnt);
    modport slave(input in_vld, in_dat, out_rdy, output in_rdy, out_vld, out_flg, out_dat, out_cnt);
endinterface

// File: rtl/sparse_enc_bank.sv
// sparse_enc_bank: one block buffer holding the flag bitmap, compacted nonzeros and count
module sparse_enc_bank
    import act_sparse_encoder_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int CHANNEL_DEPTH = DEF_CHANNEL_DEPTH
)(
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                i_we,
    input  logic                                i_last,
    input  logic                                i_clr,
    input  logic [C_LOG_2(CHANNEL_DEPTH)-1:0]   i_ch,
    input  logic [DATA_WIDTH-1:0]               i_dat,
    output logic                                o_full,
    output logic [CHANNEL_DEPTH-1:0]            o_flg,
    output logic [DATA_WIDTH*CHANNEL_DEPTH-1:0] o_dat,
    output logic [C_LOG_2(CHANNEL_DEPTH):0]     o_cnt
);
    localparam int LW = C_LOG_2(CHANNEL_DEPTH);
    bank_st_t                                r_st, w_st;
    logic [CHANNEL_DEPTH-1:0]                r_flg;
    logic [CHANNEL_DEPTH-1:0][DATA_WIDTH-1:0] r_dat;
    logic [LW:0]                             r_ptr;
    logic                                    w_nz;
    assign w_nz   = i_we && (i_dat != '0);
    assign o_full = r_st == FULL;
    assign o_flg  = r_flg;
    assign o_dat  = r_dat;
    assign o_cnt  = r_ptr;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_st <= FILL;
        else r_st <= w_st;
    end
    always_comb begin
        w_st = r_st;
        if (r_st == FILL && i_we && i_last) w_st = FULL;
        if (r_st == FULL && i_clr) w_st = FILL;
    end
    // Clearing on hand-off is what makes slots at or above the count read zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flg <= '0;
            r_dat <= '0;
            r_ptr <= '0;
        end else if (r_st == FULL && i_clr) begin
            r_flg <= '0;
            r_dat <= '0;
            r_ptr <= '0;
        end else if (w_nz) begin
            r_flg[i_ch]            <= 1'b1;
            r_dat[r_ptr[LW-1:0]]   <= i_dat;
            r_ptr                  <= r_ptr + (LW+1)'(1);
        end
    end
endmodule

// File: rtl/act_sparse_encoder.sv
// act_sparse_encoder: dense activation stream to flag/compacted-nonzero block encoder
// SPARSE_ENC_DBUF_EN selects two ping-pong banks instead of one.
module act_sparse_encoder
    import act_sparse_encoder_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int CHANNEL_DEPTH = DEF_CHANNEL_DEPTH
)(
    input logic               clk,
    input logic               rst_n,
    act_sparse_encoder_if.slave bus
);
    localparam int LW = C_LOG_2(CHANNEL_DEPTH);
`ifdef SPARSE_ENC_DBUF_EN
    localparam int NB = 2;
`else
    localparam int NB = 1;
`endif
    logic [LW-1:0]                       r_ch;
    logic                                w_wsel, w_rsel, w_in_xfer, w_out_xfer, w_last;
    logic [NB-1:0]                       w_full;
    logic [CHANNEL_DEPTH-1:0]            w_flg [NB];
    logic [DATA_WIDTH*CHANNEL_DEPTH-1:0] w_dat [NB];
    logic [LW:0]                         w_cnt [NB];
    assign bus.in_rdy  = ~w_full[w_wsel];
    assign bus.out_vld = w_full[w_rsel];
    assign bus.out_flg = w_flg[w_rsel];
    assign bus.out_dat = w_dat[w_rsel];
    assign bus.out_cnt = w_cnt[w_rsel];
    assign w_in_xfer   = bus.in_vld && bus.in_rdy;
    assign w_out_xfer  = bus.out_vld && bus.out_rdy;
    assign w_last      = r_ch == LW'(CHANNEL_DEPTH-1);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_ch <= '0;
        else if (w_in_xfer) r_ch <= r_ch + LW'(1);
    end
`ifdef SPARSE_ENC_DBUF_EN
    logic r_wsel, r_rsel;
    // Both pointers advance in block order, so the drain bank is always the oldest full one
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wsel <= 1'b0;
            r_rsel <= 1'b0;
        end else begin
            if (w_in_xfer && w_last) r_wsel <= ~r_wsel;
            if (w_out_xfer) r_rsel <= ~r_rsel;
        end
    end
    assign w_wsel = r_wsel;
    assign w_rsel = r_rsel;
`else
    assign w_wsel = 1'b0;
    assign w_rsel = 1'b0;
`endif
    for (genvar b = 0; b < NB; b++) begin : g_bank
        sparse_enc_bank #(
            .DATA_WIDTH(DATA_WIDTH),
            .CHANNEL_DEPTH(CHANNEL_DEPTH)
        ) u_bank (
            .clk(clk),
            .rst_n(rst_n),
            .i_we(w_in_xfer && (w_wsel == 1'(b))),
            .i_last(w_last),
            .i_clr(w_out_xfer && (w_rsel == 1'(b))),
            .i_ch(r_ch),
            .i_dat(bus.in_dat),
            .o_full(w_full[b]),
            .o_flg(w_flg[b]),
            .o_dat(w_dat[b]),
            .o_cnt(w_cnt[b])
        );
    end
endmodule

// File: tb/tb_act_sparse_encoder.sv
// tb_act_sparse_encoder: directed self-checking bench for act_sparse_encoder (32 x 8-bit)
module tb_act_sparse_encoder;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int n_cmp = 0;
    int n_err = 0;
    logic [7:0]   blk [32];
    logic [31:0]  m_flg, a_flg;
    logic [5:0]   m_cnt, a_cnt;
    logic [255:0] m_dat, a_dat;

    act_sparse_encoder_if bus();
    act_sparse_encoder dut(.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end

    // Reference encoding of blk: flags, ascending-channel compaction, count
    task automatic model();
        int k = 0;
        m_flg = '0;
        m_dat = '0;
        for (int i = 0; i < 32; i++) begin
            if (blk[i] != 8'd0) begin
                m_flg[i] = 1'b1;
                m_dat[k*8 +: 8] = blk[i];
                k++;
            end
        end
        m_cnt = 6'(k);
    endtask

    task automatic send(input logic [7:0] d);
        int n = 0;
        bus.in_vld = 1'b1;
        bus.in_dat = d;
        while (!bus.in_rdy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n == 100) begin
            n_cmp++;
            n_err++;
            $display("FAIL send_timeout in_rdy=%b required 1", bus.in_rdy);
        end
        @(negedge clk);
    endtask

    task automatic send_blk(input bit bub);
        for (int i = 0; i < 32; i++) begin
            if (bub && $urandom_range(0, 1) == 1) begin
                bus.in_vld = 1'b0;
                @(negedge clk);
            end
            send(blk[i]);
        end
        bus.in_vld = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.in_vld = 1'b0;
        bus.in_dat = '0;
        bus.out_rdy = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++; if (bus.in_rdy !== 1'b1) begin n_err++; $display("FAIL rst_in_rdy got %b want 1", bus.in_rdy); end
        n_cmp++; if (bus.out_vld !== 1'b0) begin n_err++; $display("FAIL rst_out_vld got %b want 0", bus.out_vld); end
        n_cmp++; if (bus.out_flg !== 32'h0) begin n_err++; $display("FAIL rst_out_flg got %h want 0", bus.out_flg); end
        n_cmp++; if (bus.out_cnt !== 6'd0) begin n_err++; $display("FAIL rst_out_cnt got %0d want 0", bus.out_cnt); end
        n_cmp++; if (bus.out_dat !== 256'h0) begin n_err++; $display("FAIL rst_out_dat got %h want 0", bus.out_dat); end
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++; if (bus.in_rdy !== 1'b1) begin n_err++; $display("FAIL rst_rel_in_rdy got %b want 1", bus.in_rdy); end
        n_cmp++; if (bus.out_vld !== 1'b0) begin n_err++; $display("FAIL rst_rel_out_vld got %b want 0", bus.out_vld); end
    endtask

    task automatic test_mixed();
        logic [255:0] e;
        e = '0;
        e[7:0] = 8'd5;
        e[15:8] = 8'd9;
        e[23:16] = 8'd200;
        for (int i = 0; i < 32; i++) blk[i] = 8'd0;
        blk[0] = 8'd5;
        blk[3] = 8'd9;
        blk[31] = 8'd200;
        bus.out_rdy = 1'b1;
        for (int i = 0; i < 31; i++) send(blk[i]);
        n_cmp++; if (bus.out_vld !== 1'b0) begin n_err++; $display("FAIL mixed_early_vld got %b want 0", bus.out_vld); end
        send(blk[31]);
        bus.in_vld = 1'b0;
        n_cmp++; if (bus.out_vld !== 1'b1) begin n_err++; $display("FAIL mixed_latency_vld got %b want 1", bus.out_vld); end
        n_cmp++; if (bus.out_flg !== 32'h80000009) begin n_err++; $display("FAIL mixed_flg got %h want 80000009", bus.out_flg); end
        n_cmp++; if (bus.out_cnt !== 6'd3) begin n_err++; $display("FAIL mixed_cnt got %0d want 3", bus.out_cnt); end
        n_cmp++; if (bus.out_dat !== e) begin n_err++; $display("FAIL mixed_dat got %h want %h", bus.out_dat, e); end
        @(negedge clk);
        n_cmp++; if (bus.out_vld !== 1'b0) begin n_err++; $display("FAIL mixed_drain_vld got %b want 0", bus.out_vld); end
        n_cmp++; if (bus.in_rdy !== 1'b1) begin n_err++; $display("FAIL mixed_drain_rdy got %b want 1", bus.in_rdy); end
    endtask

    task automatic test_zero_full();
        logic [255:0] e;
        bus.out_rdy = 1'b1;
        for (int i = 0; i < 32; i++) blk[i] = 8'd0;
        send_blk(1'b0);
        n_cmp++; if (bus.out_vld !== 1'b1) begin n_err++; $display("FAIL zero_vld got %b want 1", bus.out_vld); end
        n_cmp++; if (bus.out_flg !== 32'h0) begin n_err++; $display("FAIL zero_flg got %h want 0", bus.out_flg); end
        n_cmp++; if (bus.out_cnt !== 6'd0) begin n_err++; $display("FAIL zero_cnt got %0d want 0", bus.out_cnt); end
        n_cmp++; if (bus.out_dat !== 256'h0) begin n_err++; $display("FAIL zero_dat got %h want 0", bus.out_dat); end
        e = '0;
        for (int k = 0; k < 32; k++) begin
            blk[k] = 8'(k + 1);
            e[k*8 +: 8] = 8'(k + 1);
        end
        send_blk(1'b0);
        n_cmp++; if (bus.out_vld !== 1'b1) begin n_err++; $display("FAIL full_vld got %b want 1", bus.out_vld); end
        n_cmp++; if (bus.out_flg !== 32'hFFFFFFFF) begin n_err++; $display("FAIL full_flg got %h want ffffffff", bus.out_flg); end
        n_cmp++; if (bus.out_cnt !== 6'd32) begin n_err++; $display("FAIL full_cnt got %0d want 32", bus.out_cnt); end
        n_cmp++; if (bus.out_dat !== e) begin n_err++; $display("FAIL full_dat got %h want %h", bus.out_dat, e); end
        @(negedge clk);
        n_cmp++; if (bus.out_vld !== 1'b0) begin n_err++; $display("FAIL full_drain_vld got %b want 0", bus.out_vld); end
    endtask

    task automatic test_backpressure();
        bus.out_rdy = 1'b0;
        for (int i = 0; i < 32; i++) blk[i] = (i % 3 == 0) ? 8'(i * 2 + 1) : 8'd0;
        model();
        a_flg = m_flg;
        a_cnt = m_cnt;
        a_dat = m_dat;
        send_blk(1'b0);
`ifdef SPARSE_ENC_DBUF_EN
        for (int i = 0; i < 32; i++) blk[i] = (i % 4 == 1) ? 8'(255 - i) : 8'd0;
        model();
        send_blk(1'b0);
`endif
        for (int c = 0; c < 10; c++) begin
            n_cmp++; if (bus.out_vld !== 1'b1) begin n_err++; $display("FAIL bp_vld[%0d] got %b want 1", c, bus.out_vld); end
            n_cmp++; if (bus.in_rdy !== 1'b0) begin n_err++; $display("FAIL bp_in_rdy[%0d] got %b want 0", c, bus.in_rdy); end
            n_cmp++; if (bus.out_flg !== a_flg) begin n_err++; $display("FAIL bp_flg[%0d] got %h want %h", c, bus.out_flg, a_flg); end
            n_cmp++; if (bus.out_cnt !== a_cnt) begin n_err++; $display("FAIL bp_cnt[%0d] got %0d want %0d", c, bus.out_cnt, a_cnt); end
            n_cmp++; if (bus.out_dat !== a_dat) begin n_err++; $display("FAIL bp_dat[%0d] got %h want %h", c, bus.out_dat, a_dat); end
            @(negedge clk);
        end
        bus.out_rdy = 1'b1;
        @(negedge clk);
`ifdef SPARSE_ENC_DBUF_EN
        n_cmp++; if (bus.out_vld !== 1'b1) begin n_err++; $display("FAIL bp_second_vld got %b want 1", bus.out_vld); end
        n_cmp++; if (bus.in_rdy !== 1'b1) begin n_err++; $display("FAIL bp_second_rdy got %b want 1", bus.in_rdy); end
        n_cmp++; if (bus.out_flg !== m_flg) begin n_err++; $display("FAIL bp_second_flg got %h want %h", bus.out_flg, m_flg); end
        n_cmp++; if (bus.out_cnt !== m_cnt) begin n_err++; $display("FAIL bp_second_cnt got %0d want %0d", bus.out_cnt, m_cnt); end
        n_cmp++; if (bus.out_dat !== m_dat) begin n_err++; $display("FAIL bp_second_dat got %h want %h", bus.out_dat, m_dat); end
        @(negedge clk);
`endif
        n_cmp++; if (bus.out_vld !== 1'b0) begin n_err++; $display("FAIL bp_release_vld got %b want 0", bus.out_vld); end
        n_cmp++; if (bus.in_rdy !== 1'b1) begin n_err++; $display("FAIL bp_release_rdy got %b want 1", bus.in_rdy); end
    endtask

    task automatic test_bubbles();
        bus.out_rdy = 1'b1;
        for (int i = 0; i < 32; i++) blk[i] = (i == 0 || i % 5 == 2) ? 8'(i + 10) : 8'd0;
        model();
        send_blk(1'b1);
        n_cmp++; if (bus.out_vld !== 1'b1) begin n_err++; $display("FAIL bub_vld got %b want 1", bus.out_vld); end
        n_cmp++; if (bus.out_flg !== m_flg) begin n_err++; $display("FAIL bub_flg got %h want %h", bus.out_flg, m_flg); end
        n_cmp++; if (bus.out_cnt !== m_cnt) begin n_err++; $display("FAIL bub_cnt got %0d want %0d", bus.out_cnt, m_cnt); end
        n_cmp++; if (bus.out_dat !== m_dat) begin n_err++; $display("FAIL bub_dat got %h want %h", bus.out_dat, m_dat); end
        @(negedge clk);
        n_cmp++; if (bus.out_vld !== 1'b0) begin n_err++; $display("FAIL bub_drain_vld got %b want 0", bus.out_vld); end
    endtask

    task automatic test_reset_mid();
        bus.out_rdy = 1'b0;
        for (int i = 0; i < 17; i++) send(8'(i + 1));
        bus.in_vld = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        n_cmp++; if (bus.in_rdy !== 1'b1) begin n_err++; $display("FAIL rmid_in_rdy got %b want 1", bus.in_rdy); end
        n_cmp++; if (bus.out_vld !== 1'b0) begin n_err++; $display("FAIL rmid_vld got %b want 0", bus.out_vld); end
        n_cmp++; if (bus.out_flg !== 32'h0) begin n_err++; $display("FAIL rmid_flg got %h want 0", bus.out_flg); end
        n_cmp++; if (bus.out_cnt !== 6'd0) begin n_err++; $display("FAIL rmid_cnt got %0d want 0", bus.out_cnt); end
        n_cmp++; if (bus.out_dat !== 256'h0) begin n_err++; $display("FAIL rmid_dat got %h want 0", bus.out_dat); end
        rst_n = 1'b1;
        @(negedge clk);
        bus.out_rdy = 1'b1;
        for (int i = 0; i < 32; i++) blk[i] = 8'(i * 7);
        model();
        send_blk(1'b0);
        n_cmp++; if (bus.out_vld !== 1'b1) begin n_err++; $display("FAIL rmid_next_vld got %b want 1", bus.out_vld); end
        n_cmp++; if (bus.out_flg !== m_flg) begin n_err++; $display("FAIL rmid_next_flg got %h want %h", bus.out_flg, m_flg); end
        n_cmp++; if (bus.out_cnt !== m_cnt) begin n_err++; $display("FAIL rmid_next_cnt got %0d want %0d", bus.out_cnt, m_cnt); end
        n_cmp++; if (bus.out_dat !== m_dat) begin n_err++; $display("FAIL rmid_next_dat got %h want %h", bus.out_dat, m_dat); end
        @(negedge clk);
        n_cmp++; if (bus.out_vld !== 1'b0) begin n_err++; $display("FAIL rmid_drain_vld got %b want 0", bus.out_vld); end
    endtask

`ifdef SPARSE_ENC_DBUF_EN
    // Elements stream every cycle; block b-1 must appear exactly when block b's ch0 is driven
    task automatic test_back_to_back();
        logic ev;
        bus.out_rdy = 1'b1;
        bus.in_vld = 1'b1;
        for (int b = 0; b < 4; b++) begin
            for (int ch = 0; ch < 32; ch++) begin
                ev = (ch == 0) && (b > 0);
                n_cmp++; if (bus.in_rdy !== 1'b1) begin n_err++; $display("FAIL b2b_rdy[%0d.%0d] got %b want 1", b, ch, bus.in_rdy); end
                n_cmp++; if (bus.out_vld !== ev) begin n_err++; $display("FAIL b2b_vld[%0d.%0d] got %b want %b", b, ch, bus.out_vld, ev); end
                if (ev) begin
                    n_cmp++; if (bus.out_flg !== m_flg) begin n_err++; $display("FAIL b2b_flg[%0d] got %h want %h", b - 1, bus.out_flg, m_flg); end
                    n_cmp++; if (bus.out_cnt !== m_cnt) begin n_err++; $display("FAIL b2b_cnt[%0d] got %0d want %0d", b - 1, bus.out_cnt, m_cnt); end
                    n_cmp++; if (bus.out_dat !== m_dat) begin n_err++; $display("FAIL b2b_dat[%0d] got %h want %h", b - 1, bus.out_dat, m_dat); end
                end
                if (ch == 0) begin
                    for (int i = 0; i < 32; i++) blk[i] = ((i + b) % 3 == 0) ? 8'd0 : 8'(i * 4 + b + 1);
                    model();
                end
                bus.in_dat = blk[ch];
                @(negedge clk);
            end
        end
        bus.in_vld = 1'b0;
        n_cmp++; if (bus.out_vld !== 1'b1) begin n_err++; $display("FAIL b2b_last_vld got %b want 1", bus.out_vld); end
        n_cmp++; if (bus.out_flg !== m_flg) begin n_err++; $display("FAIL b2b_last_flg got %h want %h", bus.out_flg, m_flg); end
        n_cmp++; if (bus.out_cnt !== m_cnt) begin n_err++; $display("FAIL b2b_last_cnt got %0d want %0d", bus.out_cnt, m_cnt); end
        n_cmp++; if (bus.out_dat !== m_dat) begin n_err++; $display("FAIL b2b_last_dat got %h want %h", bus.out_dat, m_dat); end
        @(negedge clk);
        n_cmp++; if (bus.out_vld !== 1'b0) begin n_err++; $display("FAIL b2b_drain_vld got %b want 0", bus.out_vld); end
    endtask
`endif

    initial begin
        test_reset();
        test_mixed();
        test_zero_full();
        test_backpressure();
        test_bubbles();
        test_reset_mid();
`ifdef SPARSE_ENC_DBUF_EN
        test_back_to_back();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/act_sparse_encoder.md
# act_sparse_encoder

Sparse activation encoder: the writer side of the flag/compacted-data format consumed by the sparse MAC array. It accepts a dense stream of activations, one channel per cycle. For each block of CHANNEL_DEPTH channels it emits a nonzero-flag bitmap, a vector holding only the nonzero values packed toward slot 0, and a nonzero count. It sits between the activation post-processing path and the PE-cluster activation buffer that feeds the MACs.

## Interface
- DATA_WIDTH, 8, activation width in bits.
- CHANNEL_DEPTH, 32, channels per block; must be a power of 2 and at least 2.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- in_vld  in  1  dense input element valid.
- in_rdy  out  1  encoder can accept an element.
- in_dat  in  DATA_WIDTH  dense activation, unsigned.
- out_vld  out  1  encoded block valid.
- out_rdy  in  1  downstream accepts the block.
- out_flg  out  CHANNEL_DEPTH  bit i set when channel i is nonzero.
- out_dat  out  DATA_WIDTH*CHANNEL_DEPTH  packed nonzeros; slot k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- out_cnt  out  C_LOG_2(CHANNEL_DEPTH)+1  number of set bits in out_flg.

## Operation
- **Transfers.** An input transfer occurs when in_vld & in_rdy. An output transfer occurs when out_vld & out_rdy.
- **Channel counter.** ch_idx counts 0..CHANNEL_DEPTH-1 over accepted elements. It wraps to 0 after CHANNEL_DEPTH-1.
- **Nonzero element.** For the element at ch_idx with in_dat != 0:
  - flg[ch_idx] <= 1;
  - dat slot wr_ptr <= in_dat;
  - wr_ptr <= wr_ptr + 1.
- **Zero element.** The flag bit stays 0 and wr_ptr is unchanged.
- **Packing order.** Packed order follows ascending channel index. Slots at or above out_cnt read 0, because a bank is cleared when its block is handed off.
- **Bank states.** Each bank has two states:
  - FILL to FULL: on the transfer of element CHANNEL_DEPTH-1.
  - FULL to FILL: on the output transfer. At that point flg, dat and wr_ptr are cleared.
- **Boundary cases.**
  - All-zero block: out_flg=0, out_cnt=0, out_dat=0. The block is still emitted.
  - All-nonzero block: out_cnt=CHANNEL_DEPTH, and out_dat equals the input order.
  - in_vld low between elements: the encoder waits and ch_idx holds.
- **Output stability.** While out_vld=1 and out_rdy=0, out_flg, out_dat and out_cnt hold stable.
- **Reset.** Reset mid-block discards the partial block. ch_idx, wr_ptr, flg and dat all return to 0.

## Timing
- **Reset values.** in_rdy=1, out_vld=0, out_flg=0, out_dat=0, out_cnt=0.
- **Output latency.** out_vld rises the cycle after the last element's input transfer. That is a latency of 1 cycle from the last element.
- **in_rdy.** in_rdy is combinational from state registers only. There is no combinational path from in_vld, in_dat or out_rdy to any output.
- **Single buffer: input stall.** in_rdy=0 while the bank is FULL.
- **Single buffer: output transfer.** out_vld falls and in_rdy rises the cycle after the output transfer.
- **Throughput (single buffer).** Best case is one block per CHANNEL_DEPTH+1 cycles.
- **Simultaneous events.** An output transfer and an input transfer in the same cycle cannot occur in single-buffer mode. In double-buffer mode they are legal and act on different banks.

## Configuration
- **SPARSE_ENC_DBUF_EN defined.** Two banks used ping-pong:
  - Fill bank and drain bank alternate.
  - in_rdy=0 only when both banks are FULL.
  - out_* always reflect the oldest FULL bank, so block order is preserved.
  - Sustained throughput is one block per CHANNEL_DEPTH cycles with out_rdy held 1.
- **SPARSE_ENC_DBUF_EN undefined.** One bank; behaviour as in Timing.

## Structure
- **Shared header.** DATA_WIDTH and CHANNEL_DEPTH defaults and the C_LOG_2 function live in the shared params header, so the encoder and the MAC array agree on the format.
- **Sub-module sparse_enc_bank.** Holds one bank:
  - flg, dat, wr_ptr and the FULL bit;
  - inputs: write-enable, data, last and clear.
- **Instantiation.** sparse_enc_bank is instantiated once, or twice under SPARSE_ENC_DBUF_EN. The top level holds ch_idx, the bank select pointers and the output mux.

## Test plan
- **Mixed block, out_rdy=1.** CHANNEL_DEPTH=32; input ch0=5, ch3=9, ch31=200, all others 0 → out_flg=0x80000009, out_cnt=3, slots 0..2 = 5, 9, 200, slots 3..31 = 0. out_vld rises 1 cycle after ch31.
- **All zeros, then all nonzero.** Block of 32 zeros → out_flg=0, out_cnt=0, out_dat=0. Next block in_dat=ch+1 → out_flg=0xFFFFFFFF, out_cnt=32, slot k = k+1. The second block must carry no stale data.
- **Backpressure.** out_rdy=0 for 10 cycles after out_vld → outputs stable. Single buffer: in_rdy=0 throughout, and in_rdy=1 one cycle after out_rdy=1. Double buffer: the second block fills, then in_rdy=0.
- **Input bubbles.** in_vld toggled randomly at 50% → same encoding as the gap-free stream; ch_idx unaffected by idle cycles.
- **Reset mid-block.** rst_n asserted after 17 elements → all outputs return to reset values. The next full block encodes correctly from ch0.
- **Double buffer only.** 4 back-to-back blocks with out_rdy=1 → one block per 32 cycles, in order, and in_rdy never drops.
